// File: rtl/core_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner and word-address helpers.
package core_pkg;

   localparam int WADDR_W = 30;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   function automatic logic [WADDR_W-1:0] word_index(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if;
   import core_pkg::*;

   logic               if_req;
   logic [31:0]        if_addr;
   logic               if_flush;
   logic               if_ack;
   logic [31:0]        if_rdata;
   logic               dm_req;
   logic               dm_we;
   logic [31:0]        dm_addr;
   logic [31:0]        dm_wdata;
   logic               dm_ack;
   logic [31:0]        dm_rdata;
   logic [WADDR_W-1:0] mem_addr;
   logic [31:0]        mem_wdata;
   logic               mem_re;
   logic               mem_we;
   logic [31:0]        mem_rdata;
   logic               stall;

   modport slave (
      input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wdata, mem_re, mem_we, stall
   );

   modport master (
      output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wdata, mem_re, mem_we, stall
   );

endinterface

// File: rtl/mem_access_timer.sv
// Access-length down-counter: loads MEM_LAT-1 at grant, flags the last and next-to-last cycles.
module mem_access_timer #(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic last,
   output logic penult
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (run && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last   = (cnt_q == '0);
   assign penult = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word memory between fetch and data stages; data favoured, fetch starvation bounded
// by MAX_DATA_RUN. Each transfer is IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack).
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int MEM_LAT      = 1,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   localparam int RW = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

   arb_state_e         state_q, state_d;
   owner_e             owner_q, owner_d;
   logic               we_q, we_d;
   logic               flushed_q, flushed_d;
   logic [RW-1:0]      run_q, run_d;
   logic               if_ack_q, if_ack_d;
   logic               dm_ack_q, dm_ack_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        dm_rdata_q, dm_rdata_d;
   logic [WADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               mem_re_q, mem_re_d;
   logic               mem_we_q, mem_we_d;

   logic timer_load;
   logic timer_last;
   logic timer_penult;
   logic fetch_pend;
   logic grant_if;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

   mem_access_timer #(.MEM_LAT(MEM_LAT)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .run    (state_q == ST_ACCESS),
      .last   (timer_last),
      .penult (timer_penult)
   );

   // A flushed fetch is not eligible for the grant in the same cycle.
   assign fetch_pend = bus.if_req & ~bus.if_flush;
   assign grant_if   = fetch_pend & (~bus.dm_req | (run_q >= RUN_MAX));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      flushed_d   = flushed_q;
      run_d       = run_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_re_d    = mem_re_q;
      mem_we_d    = 1'b0;
      timer_load  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fetch_pend || bus.dm_req) begin
               state_d    = ST_ACCESS;
               timer_load = 1'b1;
               flushed_d  = 1'b0;
               if (grant_if) begin
                  owner_d     = OWN_IF;
                  we_d        = 1'b0;
                  mem_addr_d  = word_index(bus.if_addr);
                  mem_wdata_d = '0;
                  run_d       = '0;
               end else begin
                  owner_d     = OWN_DM;
                  we_d        = bus.dm_we;
                  mem_addr_d  = word_index(bus.dm_addr);
                  mem_wdata_d = bus.dm_wdata;
                  if (bus.if_req && (run_q < RUN_MAX)) begin
                     run_d = run_q + RW'(1);
                  end
               end
               mem_re_d = ~we_d;
               mem_we_d = we_d && (MEM_LAT == 1);
            end
         end
         ST_ACCESS: begin
            if ((owner_q == OWN_IF) && bus.if_flush) begin
               flushed_d = 1'b1;
            end
            if (timer_last) begin
               state_d  = ST_RESP;
               mem_re_d = 1'b0;
               if (owner_q == OWN_DM) begin
                  dm_ack_d   = 1'b1;
                  dm_rdata_d = we_q ? 32'h0 : bus.mem_rdata;
               end else if (!(flushed_q || bus.if_flush)) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end else begin
               // Strobe lands on the final access cycle only.
               mem_we_d = we_q & timer_penult;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!bus.if_req) begin
         run_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         flushed_q   <= 1'b0;
         run_q       <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         flushed_q   <= flushed_d;
         run_q       <= run_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign bus.if_ack    = if_ack_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1, 2, 3) each with its own word memory model.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        if_req   [3];
   logic        if_flush [3];
   logic        dm_req   [3];
   logic        dm_we    [3];
   logic [31:0] if_addr  [3];
   logic [31:0] dm_addr  [3];
   logic [31:0] dm_wdata [3];
   logic        if_ack   [3];
   logic        dm_ack   [3];
   logic        mem_re   [3];
   logic        mem_we   [3];
   logic        stall    [3];
   logic [31:0] if_rdata [3];
   logic [31:0] dm_rdata [3];
   logic [31:0] mem_wdata[3];
   logic [29:0] mem_addr [3];

   int total = 0;
   int bad   = 0;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mem_port_arbiter_if bus();
      logic [31:0] mem [64];
      int we_cnt = 0;

      assign bus.if_req   = if_req[gi];
      assign bus.if_flush = if_flush[gi];
      assign bus.if_addr  = if_addr[gi];
      assign bus.dm_req   = dm_req[gi];
      assign bus.dm_we    = dm_we[gi];
      assign bus.dm_addr  = dm_addr[gi];
      assign bus.dm_wdata = dm_wdata[gi];
      assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr[5:0]] : 32'h0;

      assign if_ack[gi]    = bus.if_ack;
      assign dm_ack[gi]    = bus.dm_ack;
      assign mem_re[gi]    = bus.mem_re;
      assign mem_we[gi]    = bus.mem_we;
      assign stall[gi]     = bus.stall;
      assign if_rdata[gi]  = bus.if_rdata;
      assign dm_rdata[gi]  = bus.dm_rdata;
      assign mem_wdata[gi] = bus.mem_wdata;
      assign mem_addr[gi]  = bus.mem_addr;

      initial begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
         mem[2] <= 32'h0020_6413;
      end

      always @(posedge clk) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
         end
      end

      mem_port_arbiter #(.MEM_LAT(gi + 1), .MAX_DATA_RUN(4)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      string      exp_s;
      logic [7:0] got [10];
      int         n;
      logic       act;

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if_req[k] = 1'b0;  if_flush[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
         if_addr[k] = '0;   dm_addr[k] = '0;    dm_wdata[k] = '0;
      end
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst%0d_if_ack", k),   32'(if_ack[k]),   32'h0);
         chk($sformatf("rst%0d_mem_re", k),   32'(mem_re[k]),   32'h0);
         chk($sformatf("rst%0d_mem_we", k),   32'(mem_we[k]),   32'h0);
         chk($sformatf("rst%0d_stall", k),    32'(stall[k]),    32'h0);
         chk($sformatf("rst%0d_mem_addr", k), 32'(mem_addr[k]), 32'h0);
      end
      rst = 1'b0;
      tick();

      // Fetch, MEM_LAT=1: ack two cycles after the sampling cycle.
      if_req[0] = 1'b1; if_addr[0] = 32'h8;
      tick();
      chk("t1_mem_re",   32'(mem_re[0]),   32'h1);
      chk("t1_mem_addr", 32'(mem_addr[0]), 32'h2);
      chk("t1_stall",    32'(stall[0]),    32'h1);
      tick();
      chk("t1_if_ack",   32'(if_ack[0]),   32'h1);
      chk("t1_if_rdata", if_rdata[0],      32'h0020_6413);
      chk("t1_stall_ack", 32'(stall[0]),   32'h0);
      if_req[0] = 1'b0;
      tick();
      chk("t1_ack_pulse", 32'(if_ack[0]),  32'h0);

      // Store, MEM_LAT=3: strobe in cycle 3 at word 4, ack in cycle 4.
      dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 32'h10; dm_wdata[2] = 32'hCAFE;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("t2_mem_we_c%0d", c), 32'(mem_we[2]), 32'(c == 3));
         chk($sformatf("t2_dm_ack_c%0d", c), 32'(dm_ack[2]), 32'(c == 4));
         if (c == 3) chk("t2_mem_addr", 32'(mem_addr[2]), 32'h4);
      end
      dm_req[2] = 1'b0; dm_we[2] = 1'b0;
      tick();
      chk("t2_ack_pulse", 32'(dm_ack[2]),     32'h0);
      chk("t2_word4",     g_dut[2].mem[4],    32'hCAFE);
      chk("t2_we_count",  32'(g_dut[2].we_cnt), 32'h1);
      chk("t2_dm_rdata",  dm_rdata[2],        32'h0);

      // Both requesting continuously: fetch gets every fifth grant.
      exp_s = "DDDDIDDDDI";
      if_req[0] = 1'b1; if_addr[0] = 32'h8;
      dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h4;
      n = 0;
      for (int c = 0; c < 40 && n < 10; c++) begin
         tick();
         chk("t3_both_acks", 32'(if_ack[0] & dm_ack[0]), 32'h0);
         if (if_ack[0]) begin
            got[n] = "I"; n++;
         end else if (dm_ack[0]) begin
            got[n] = "D"; n++;
         end
      end
      if_req[0] = 1'b0; dm_req[0] = 1'b0;
      chk("t3_grant_count", 32'(n), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t3_grant%0d", i), 32'(got[i]), 32'(exp_s[i]));
      end
      tick();

      // Flush during a fetch, MEM_LAT=2: no ack, rdata kept; then a flushed IDLE request is skipped.
      if_req[1] = 1'b1; if_addr[1] = 32'hC;
      tick();
      chk("t4_mem_re", 32'(mem_re[1]), 32'h1);
      if_flush[1] = 1'b1; if_req[1] = 1'b0;
      tick();
      if_flush[1] = 1'b0;
      tick();
      chk("t4_no_ack",      32'(if_ack[1]), 32'h0);
      chk("t4_rdata_kept",  if_rdata[1],    32'h0);
      tick();
      chk("t4_no_ack_late", 32'(if_ack[1]), 32'h0);
      if_req[1] = 1'b1; if_addr[1] = 32'h8; if_flush[1] = 1'b1;
      tick();
      chk("t4_flush_idle_no_grant", 32'(mem_re[1]), 32'h0);
      if_flush[1] = 1'b0;
      tick();
      tick();
      tick();
      chk("t4_refetch_ack",   32'(if_ack[1]), 32'h1);
      chk("t4_refetch_rdata", if_rdata[1],    32'h0020_6413);
      if_req[1] = 1'b0;
      tick();

      // Reset in the last access cycle of a store to 0x20: no write reaches memory.
      dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 32'h20; dm_wdata[2] = 32'hDEAD;
      tick();
      tick();
      tick();
      rst = 1'b1; dm_req[2] = 1'b0; dm_we[2] = 1'b0;
      #1;
      chk("t5_mem_we_rst", 32'(mem_we[2]), 32'h0);
      tick();
      chk("t5_word8",      g_dut[2].mem[8],          32'h8);
      chk("t5_we_count",   32'(g_dut[2].we_cnt),     32'h1);
      chk("t5_mem_re",     32'(mem_re[2]),           32'h0);
      chk("t5_mem_addr",   32'(mem_addr[2]),         32'h0);
      chk("t5_mem_wdata",  mem_wdata[2],             32'h0);
      rst = 1'b0;
      act = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         act = act | dm_ack[2] | mem_we[2];
      end
      chk("t5_no_late_ack", 32'(act), 32'h0);

      // Quiet period, then a data read of word 1.
      act = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         act = act | stall[0] | mem_re[0] | mem_we[0];
      end
      chk("t6_idle_quiet", 32'(act), 32'h0);
      dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h4;
      tick();
      tick();
      chk("t6_dm_ack",   32'(dm_ack[0]), 32'h1);
      chk("t6_dm_rdata", dm_rdata[0],    32'h1);
      dm_req[0] = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
